rr_reg_arbiter: RTL and testbench



---
 rtl/rr_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_rr_reg_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_reg_arbiter.sv
// Round-robin access controller for one shared WIDTH-bit register among N_REQ requesters.
// Latency: grant one edge after a request in IDLE; the owner's write is visible one edge after that.
// Backpressure: non-owner requests wait until release; the owner is forced off after MAX_HOLD writes.
module rr_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wr_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [OW-1:0]            owner
);

  localparam int HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;

  logic               do_write;
  logic               forced;
  logic [N_REQ-1:0]   cand;
  logic [OW:0]        win;

  // First set bit of cand scanning from start upward with wrap; MSB of result flags "found".
  function automatic logic [OW:0] pick(input logic [N_REQ-1:0] c, input logic [OW-1:0] start);
    logic [OW:0] res;
    int          idx;
    res = '0;
    // Scan from the far end so the candidate closest to start is written last and wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_REQ;
      if (c[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Next-state: arbitration in IDLE, owner writes and release/re-arbitration in GRANT.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    do_write = 1'b0;
    forced   = 1'b0;
    cand     = req;
    win      = '0;
    case (state_q)
      IDLE: begin
        win = pick(req, ptr_q);
        if (win[OW]) begin
          gnt_d   = onehot(win[OW-1:0]);
          owner_d = win[OW-1:0];
          hold_d  = '0;
          state_d = GRANT;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        do_write = req[owner_q];
        if (do_write) begin
          data_d  = wr_data[owner_q*WIDTH +: WIDTH];
          valid_d = 1'b1;
          hold_d  = hold_q + 1'b1;
          forced  = (hold_q == HW'(MAX_HOLD - 1));
        end
        if (!do_write || forced) begin
          ptr_d = OW'((int'(owner_q) + 1) % N_REQ);
          // A forced release hands over to someone else when possible; a lone owner keeps going.
          if (forced) begin
            cand[owner_q] = 1'b0;
            if (cand == '0) cand = req;
          end
          win = pick(cand, ptr_d);
          if (win[OW]) begin
            gnt_d   = onehot(win[OW-1:0]);
            owner_d = win[OW-1:0];
            hold_d  = '0;
          end else begin
            gnt_d   = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset that discards any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Testbench for rr_reg_arbiter: directed scenarios plus a per-cycle reference model compare.
// Latency: model advances on each rising edge; outputs are compared on the falling edge.
// Backpressure: not applicable; stimulus is driven on falling edges only.
module tb_rr_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] wr_data;
  logic [N-1:0] gnt;
  logic [W-1:0] q;
  logic         q_valid;
  logic [1:0]   owner;

  int errors = 0;
  int checks = 0;

  rr_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_data(wr_data),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the register (-1 = nobody), how many writes
  // it has made in this tenure, and where the next search begins.
  int        m_holder = -1;
  int        m_last   = 0;
  int        m_writes = 0;
  int        m_ptr    = 0;
  logic [7:0] m_q     = 8'h00;
  logic      m_qv     = 1'b0;
  bit        m_init   = 1'b0;

  function automatic int m_pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_holder = -1; m_last = 0; m_writes = 0; m_ptr = 0;
      m_q = 8'h00; m_qv = 1'b0; m_init = 1'b1;
    end else begin
      m_qv = 1'b0;
      if (m_holder < 0) begin
        int w;
        w = m_pick(req, m_ptr, -1);
        if (w >= 0) begin m_holder = w; m_last = w; m_writes = 0; end
      end else begin
        int  o;
        int  w;
        bit  leave;
        bit  hit_limit;
        o = m_holder; leave = 1'b0; hit_limit = 1'b0;
        if (req[o]) begin
          m_q = wr_data[o*W +: W];
          m_qv = 1'b1;
          m_writes++;
          if (m_writes == MH) hit_limit = 1'b1;
        end else begin
          leave = 1'b1;
        end
        if (leave || hit_limit) begin
          m_ptr = (o + 1) % N;
          w = m_pick(req, m_ptr, hit_limit ? o : -1);
          if (w < 0 && hit_limit) w = o;
          m_holder = w;
          if (w >= 0) begin m_last = w; m_writes = 0; end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_gnt", 32'(gnt), (m_holder < 0) ? 32'd0 : (32'd1 << m_holder));
      chk("model_owner", 32'(owner), 32'(m_last));
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_q_valid", 32'(q_valid), 32'(m_qv));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    wr_data[i*W +: W] = v;
  endtask

  logic [N-1:0] hist [0:8];
  logic [7:0]   qhist [0:8];

  initial begin
    rst = 1'b1; req = 4'b1111; wr_data = '0;

    // 1: reset holds everything at zero despite requests
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick(); tick();

    // 2: single requester, two writes, then next search starts at 3
    req = 4'b0100; set_data(2, 8'hA5);
    tick(); chk("t2_gnt", 32'(gnt), 32'b0100);
    tick(); chk("t2_q1", 32'(q), 32'hA5); chk("t2_qv1", 32'(q_valid), 32'h1);
    tick(); chk("t2_q2", 32'(q), 32'hA5); chk("t2_qv2", 32'(q_valid), 32'h1);
    req = 4'b0000;
    tick(); chk("t2_release", 32'(gnt), 32'h0); chk("t2_qv_off", 32'(q_valid), 32'h0);
    req = 4'b1001;
    tick(); chk("t2_ptr3", 32'(gnt), 32'b1000);
    req = 4'b0000;
    tick(); tick();

    // 3: simultaneous requests from reset, handover without an idle cycle
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1010; set_data(1, 8'h11); set_data(3, 8'h33);
    tick(); chk("t3_gnt1", 32'(gnt), 32'b0010);
    tick(); chk("t3_q1", 32'(q), 32'h11);
    req = 4'b1000;
    tick(); chk("t3_gnt3", 32'(gnt), 32'b1000); chk("t3_owner3", 32'(owner), 32'd3);
    tick(); chk("t3_q3", 32'(q), 32'h33);
    req = 4'b0000;
    tick(); chk("t3_idle", 32'(gnt), 32'h0);

    // 4: forced rotation between two persistent requesters
    set_data(0, 8'h40); set_data(1, 8'h41);
    req = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      tick();
      hist[k] = gnt;
      qhist[k] = q;
    end
    for (int k = 0; k < 9; k++)
      chk("t4_rot", 32'(hist[k]), (k >= 4 && k < 8) ? 32'b0010 : 32'b0001);
    chk("t4_q_last0", 32'(qhist[4]), 32'h40);
    chk("t4_q_last1", 32'(qhist[8]), 32'h41);
    req = 4'b0000;
    tick(); tick();

    // 5: lone requester keeps the grant across limit boundaries
    set_data(3, 8'h5C);
    req = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_gnt", 32'(gnt), 32'b1000);
      if (k >= 1) chk("t5_qv", 32'(q_valid), 32'h1);
    end
    req = 4'b0000;
    tick(); tick();

    // 6: reset during the second write; pointer must return to 0
    req = 4'b0010; tick();
    req = 4'b0000; tick(); tick();
    req = 4'b0100; set_data(2, 8'hC3); set_data(0, 8'h0E);
    tick(); chk("t6_gnt2", 32'(gnt), 32'b0100);
    tick(); chk("t6_q1", 32'(q), 32'hC3);
    rst = 1'b1;
    tick(); chk("t6_q_disc", 32'(q), 32'h0); chk("t6_gnt_off", 32'(gnt), 32'h0);
    chk("t6_qv_off", 32'(q_valid), 32'h0);
    rst = 1'b0; req = 4'b0101;
    tick(); chk("t6_regrant0", 32'(gnt), 32'b0001);
    tick(); chk("t6_q0", 32'(q), 32'h0E);
    req = 4'b0000;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
